// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: a one-entry register between decode and execute.
// It holds one decoded instruction, resolves operand forwarding from the
// EX/MEM and MEM/WB producers, and selects the ALU's second operand.
//
// Handshake: valid/ready on both sides. A transfer happens on a rising clock
// edge where valid && ready are both high. The sender keeps valid and its data
// stable until the transfer. This stage raises in_ready whenever its entry is
// empty or is being drained in the same cycle, so it sustains full throughput.
// flush drops both the held entry and any instruction offered in that cycle.
module id_ex_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    // decode side
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] RD1,
    input  logic [n-1:0] RD2,
    input  logic [n-1:0] ImmExt,
    input  logic [n-1:0] PCIn,
    input  logic [4:0]   Rs1,
    input  logic [4:0]   Rs2,
    input  logic [4:0]   RdIn,
    input  logic         ALUSrcIn,
    input  logic [2:0]   ALUControlIn,
    input  logic         RegWriteIn,
    input  logic         flush,

    // forwarding producers
    input  logic         FwdMemRegWrite,
    input  logic [4:0]   FwdMemRd,
    input  logic [n-1:0] FwdMemData,
    input  logic         FwdWbRegWrite,
    input  logic [4:0]   FwdWbRd,
    input  logic [n-1:0] FwdWbData,

    // execute side
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] SrcA,
    output logic [n-1:0] SrcB,
    output logic [2:0]   ALUControl,
    output logic [n-1:0] StoreData,
    output logic [n-1:0] PCOut,
    output logic [4:0]   RdOut,
    output logic         RegWriteOut
);

    // held instruction fields
    logic [n-1:0] rd1_q;
    logic [n-1:0] rd2_q;
    logic [n-1:0] imm_q;
    logic [n-1:0] pc_q;
    logic [4:0]   rs1_q;
    logic [4:0]   rs2_q;
    logic [4:0]   rd_q;
    logic         alusrc_q;
    logic [2:0]   aluctl_q;
    logic         regwrite_q;
    logic         valid_q;

    logic         capture;
    logic [n-1:0] rs2_val;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // valid bit: reset beats flush, flush beats capture, capture beats drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // payload registers load only on an accepted, non-flushed instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alusrc_q   <= 1'b0;
            aluctl_q   <= 3'b000;
            regwrite_q <= 1'b0;
        end else if (capture) begin
            rd1_q      <= RD1;
            rd2_q      <= RD2;
            imm_q      <= ImmExt;
            pc_q       <= PCIn;
            rs1_q      <= Rs1;
            rs2_q      <= Rs2;
            rd_q       <= RdIn;
            alusrc_q   <= ALUSrcIn;
            aluctl_q   <= ALUControlIn;
            regwrite_q <= RegWriteIn;
        end
    end

    // operand A forwarding: the younger EX/MEM producer wins; x0 never forwards
    always_comb begin
        SrcA = rd1_q;
        if (rs1_q != 5'd0 && FwdMemRegWrite && FwdMemRd == rs1_q) begin
            SrcA = FwdMemData;
        end else if (rs1_q != 5'd0 && FwdWbRegWrite && FwdWbRd == rs1_q) begin
            SrcA = FwdWbData;
        end
    end

    // rs2 forwarding, same priority as operand A
    always_comb begin
        rs2_val = rd2_q;
        if (rs2_q != 5'd0 && FwdMemRegWrite && FwdMemRd == rs2_q) begin
            rs2_val = FwdMemData;
        end else if (rs2_q != 5'd0 && FwdWbRegWrite && FwdWbRd == rs2_q) begin
            rs2_val = FwdWbData;
        end
    end

    assign SrcB        = alusrc_q ? imm_q : rs2_val;
    assign StoreData   = rs2_val;
    assign ALUControl  = aluctl_q;
    assign PCOut       = pc_q;
    assign RdOut       = rd_q;
    assign RegWriteOut = valid_q && regwrite_q;
    assign out_valid   = valid_q;

endmodule
